// File: rtl/demux_pkg.sv
// Shared constants and FSM state type for the 1-to-4 stream demultiplexer.
package demux_pkg;

    localparam int NUM_LANES = 4;
    localparam int SEL_W     = 2;

    typedef enum logic {
        IDLE,
        BURST
    } demux_state_t;

endpackage

// File: rtl/demux_lane_reg.sv
// One-entry valid/ready register slice for a single demux output lane.
module demux_lane_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] d_data,
    input  logic              d_last,
    output logic              lane_ready,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last
);

    assign lane_ready = ~m_valid | m_ready;

    // Payload is only rewritten on load, so an idle lane keeps its last beat visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
        end else if (load) begin
            m_valid <= 1'b1;
            m_data  <= d_data;
            m_last  <= d_last;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_demux_1x4.sv
// 1-to-4 registered stream demultiplexer with per-packet lane locking.
// Optional per-lane accepted-beat counters on cnt_bus when DEMUX_CNT_EN is defined.
module stream_demux_1x4
    import demux_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [DATA_W-1:0]             s_data,
    input  logic [SEL_W-1:0]              s_sel,
    input  logic                          s_last,
    output logic [NUM_LANES-1:0]          m_valid,
    input  logic [NUM_LANES-1:0]          m_ready,
    output logic [NUM_LANES*DATA_W-1:0]   m_data,
    output logic [NUM_LANES-1:0]          m_last,
    output logic                          busy
`ifdef DEMUX_CNT_EN
    ,
    output logic [NUM_LANES*CNT_W-1:0]    cnt_bus
`endif
);

    if (DATA_W < 1 || CNT_W < 1) begin : g_bad_params
        $error("stream_demux_1x4: DATA_W and CNT_W must be >= 1");
    end

    demux_state_t         state_q, state_d;
    logic [SEL_W-1:0]     lock_q, lock_d;
    logic [SEL_W-1:0]     dest;
    logic                 accept;
    logic [NUM_LANES-1:0] load;
    logic [NUM_LANES-1:0] lane_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lock_q  <= '0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
        end
    end

    // s_ready is deliberately combinational from m_ready/s_sel through the lane mux.
    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        load    = '0;
        dest    = (state_q == IDLE) ? s_sel : lock_q;
        s_ready = lane_ready[dest];
        accept  = s_valid & s_ready;
        busy    = (state_q == BURST);
        load[dest] = accept;

        case (state_q)
            IDLE: begin
                if (accept && !s_last) begin
                    lock_d  = s_sel;
                    state_d = BURST;
                end
            end
            BURST: begin
                if (accept && s_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        demux_lane_reg #(
            .DATA_W (DATA_W)
        ) u_lane (
            .clk        (clk),
            .rst_n      (rst_n),
            .load       (load[i]),
            .d_data     (s_data),
            .d_last     (s_last),
            .lane_ready (lane_ready[i]),
            .m_valid    (m_valid[i]),
            .m_ready    (m_ready[i]),
            .m_data     (m_data[i*DATA_W +: DATA_W]),
            .m_last     (m_last[i])
        );
    end

`ifdef DEMUX_CNT_EN
    logic [CNT_W-1:0] cnt_q [NUM_LANES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_LANES; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_LANES; i++) begin
                if (load[i]) begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        cnt_bus = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            cnt_bus[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_stream_demux_1x4.sv
// Self-checking bench for stream_demux_1x4: directed scenarios plus random traffic
// against a lane-occupancy reference model (counter checks when DEMUX_CNT_EN is defined).
module tb_stream_demux_1x4;

    localparam int DW = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic [1:0]    s_sel;
    logic          s_last;
    logic [3:0]    m_valid;
    logic [3:0]    m_ready;
    logic [4*DW-1:0] m_data;
    logic [3:0]    m_last;
    logic          busy;
`ifdef DEMUX_CNT_EN
    logic [4*CW-1:0] cnt_bus;
`endif

    stream_demux_1x4 #(
        .DATA_W (DW),
        .CNT_W  (CW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_sel   (s_sel),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_last  (m_last),
        .busy    (busy)
`ifdef DEMUX_CNT_EN
        ,
        .cnt_bus (cnt_bus)
`endif
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Reference model: packet state and what each lane should currently present.
    bit          in_pkt;
    logic [1:0]  locked;
    bit          occ   [4];
    logic [7:0]  lastd [4];
    logic        lastl [4];
    int unsigned cnt   [4];

    // Producer-side hold tracking.
    bit          prev_stall;
    logic [1:0]  prev_sel;
    logic [7:0]  prev_data;
    logic        prev_last;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        in_pkt = 0;
        locked = '0;
        prev_stall = 0;
        for (int i = 0; i < 4; i++) begin
            occ[i] = 0; lastd[i] = '0; lastl[i] = 1'b0; cnt[i] = 0;
        end
    endtask

    function automatic logic [1:0] model_dest();
        return in_pkt ? locked : s_sel;
    endfunction

    function automatic logic model_sready();
        logic [1:0] d;
        d = model_dest();
        return !occ[d] || m_ready[d];
    endfunction

    task automatic check_all();
        chk("s_ready", 64'(s_ready), 64'(model_sready()));
        chk("busy", 64'(busy), 64'(in_pkt));
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("m_valid[%0d]", i), 64'(m_valid[i]), 64'(occ[i]));
            chk($sformatf("m_data[%0d]", i), 64'(m_data[i*DW +: DW]), 64'(lastd[i]));
            chk($sformatf("m_last[%0d]", i), 64'(m_last[i]), 64'(lastl[i]));
`ifdef DEMUX_CNT_EN
            chk($sformatf("cnt[%0d]", i), 64'(cnt_bus[i*CW +: CW]), 64'(cnt[i] % (1 << CW)));
`endif
        end
    endtask

    task automatic model_update();
        logic [1:0] d;
        logic       sr;
        d  = model_dest();
        sr = model_sready();
        for (int i = 0; i < 4; i++) begin
            if (occ[i] && m_ready[i]) occ[i] = 0;
        end
        if (s_valid && sr) begin
            occ[d] = 1; lastd[d] = s_data; lastl[d] = s_last; cnt[d]++;
            if (!in_pkt) locked = s_sel;
            in_pkt = !s_last;
        end
    endtask

    // Called just after a falling edge; returns with the next falling edge passed.
    task automatic step(input logic v, input logic [1:0] sel, input logic [7:0] d,
                        input logic l, input logic [3:0] mr, output logic acc);
        s_valid = v; s_sel = sel; s_data = d; s_last = l; m_ready = mr;
        if (prev_stall) begin
            assert (v && sel === prev_sel && d === prev_data && l === prev_last) else begin
                errors++;
                $error("FAIL producer_hold observed=%0h expected=%0h", {sel, d, l}, {prev_sel, prev_data, prev_last});
            end
        end
        #2;
        check_all();
        acc = s_ready & v;
        prev_stall = v & !s_ready;
        prev_sel = sel; prev_data = d; prev_last = l;
        model_update();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        s_valid = 1'b1; s_sel = 2'd1; s_data = 8'hEE; s_last = 1'b0; m_ready = 4'h0;
        #2;
        model_reset();
        check_all();
        chk("rst_m_valid", 64'(m_valid), 64'h0);
        chk("rst_s_ready", 64'(s_ready), 64'h1);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic       acc;
        bit         pend;
        logic [1:0] rs;
        logic [7:0] rd;
        logic       rl;
        logic       v;

        rst_n = 1'b0;
        s_valid = 1'b0; s_sel = '0; s_data = '0; s_last = 1'b0; m_ready = '0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Single-beat routing
        step(1'b1, 2'd2, 8'hA5, 1'b1, 4'hF, acc);
        chk("single_a5_acc", 64'(acc), 64'h1);
        chk("single_a5_lane2", 64'({m_valid[2], m_data[2*DW +: DW]}), 64'h1A5);
        step(1'b1, 2'd0, 8'h3C, 1'b1, 4'hF, acc);
        chk("single_3c_lane0", 64'({m_valid[0], m_data[0 +: DW]}), 64'h13C);
        chk("single_idle", 64'(busy), 64'h0);
        step(1'b0, 2'd0, 8'h00, 1'b0, 4'hF, acc);

        // Burst lock to lane 1 despite s_sel moving to 3
        for (int b = 0; b < 4; b++) begin
            step(1'b1, (b == 0) ? 2'd1 : 2'd3, 8'(8'h10 + b), (b == 3), 4'hF, acc);
            chk($sformatf("burst_lane1_b%0d", b), 64'({m_valid[1], m_data[DW +: DW]}), 64'({1'b1, 8'(8'h10 + b)}));
            chk($sformatf("burst_lane3_quiet_b%0d", b), 64'(m_valid[3]), 64'h0);
            chk($sformatf("burst_busy_b%0d", b), 64'(busy), 64'((b != 3) ? 1 : 0));
        end
        step(1'b0, 2'd0, 8'h00, 1'b0, 4'hF, acc);

        // Back-pressure isolation
        step(1'b1, 2'd1, 8'h55, 1'b1, 4'h0, acc);
        step(1'b1, 2'd0, 8'h66, 1'b1, 4'h0, acc);
        step(1'b1, 2'd1, 8'h77, 1'b1, 4'b0001, acc);
        chk("bp_blocked", 64'(acc), 64'h0);
        chk("bp_lane0_drained", 64'(m_valid[0]), 64'h0);
        chk("bp_lane1_held", 64'({m_valid[1], m_data[DW +: DW]}), 64'h155);
        step(1'b1, 2'd1, 8'h77, 1'b1, 4'b0010, acc);
        chk("bp_passthrough", 64'(acc), 64'h1);
        chk("bp_lane1_new", 64'({m_valid[1], m_data[DW +: DW]}), 64'h177);
        step(1'b0, 2'd0, 8'h00, 1'b0, 4'hF, acc);

        // Reset mid-burst
        for (int b = 0; b < 3; b++) step(1'b1, 2'd2, 8'(8'h40 + b), 1'b0, 4'hF, acc);
        chk("mid_busy", 64'(busy), 64'h1);
        do_reset();
        chk("mid_rst_busy", 64'(busy), 64'h0);
        step(1'b1, 2'd3, 8'h99, 1'b1, 4'h0, acc);
        chk("mid_post_lane3", 64'({m_valid, m_data[3*DW +: DW]}), 64'h899);

`ifdef DEMUX_CNT_EN
        do_reset();
        for (int b = 0; b < 17; b++) step(1'b1, 2'd2, 8'(b), 1'b1, 4'hF, acc);
        chk("cnt_lane2_wrap", 64'(cnt_bus), 64'h0100);
`endif

        // Random traffic against the model
        do_reset();
        pend = 0; rs = '0; rd = '0; rl = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (!pend) begin
                rs = 2'($urandom_range(0, 3));
                rd = 8'($urandom);
                rl = ($urandom_range(0, 2) == 0);
            end
            v = pend ? 1'b1 : ($urandom_range(0, 3) != 0);
            step(v, rs, rd, rl, 4'($urandom), acc);
            pend = v && !acc;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stream_demux_1x4.md
Name: stream_demux_1x4

Overview:
- 1-to-4 registered stream demultiplexer. It is the distributing counterpart of the team's 4:1 select muxes.
- One valid/ready input stream is routed to one of four valid/ready output lanes, selected by a 2-bit select.
- A packet (s_last-delimited) is locked to one lane for its whole duration.
- Sits between a single producer and four per-channel consumers in the datapath.

Parameters:
- DATA_W, 8, payload width per beat.
- CNT_W, 16, width of per-lane beat counters (used only with DEMUX_CNT_EN).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- s_valid  input  1  input beat valid.
- s_ready  output  1  input beat accepted when s_valid & s_ready.
- s_data  input  DATA_W  input payload.
- s_sel  input  2  destination lane. Sampled only on the first beat of a packet.
- s_last  input  1  final beat of packet.
- m_valid  output  4  per-lane valid.
- m_ready  input  4  per-lane ready.
- m_data  output  4*DATA_W  lane i payload at bits [i*DATA_W +: DATA_W].
- m_last  output  4  per-lane last flag.
- busy  output  1  high while in BURST state.
- cnt_bus  output  4*CNT_W  per-lane accepted-beat counters. Present only with DEMUX_CNT_EN.

Behaviour:
- Reset:
  - rst_n low forces, asynchronously: m_valid=0, m_data=0, m_last=0, busy=0, FSM=IDLE, locked lane=0, counters=0.
  - Reset mid-packet drops all buffered beats. After release, the next accepted beat is treated as the first beat of a new packet.
- Lane register (x4): one entry each.
  - lane_ready[i] = ~m_valid[i] | m_ready[i].
  - On load: m_valid[i]=1, and m_data and m_last are captured.
  - On m_valid[i] & m_ready[i] with no load: m_valid[i]=0.
  - Unload and load in the same cycle: the register holds the new beat and m_valid stays 1. Full throughput is 1 beat/clk per lane.
- Lane select: dest = (FSM==IDLE) ? s_sel : locked_lane.
- s_ready = lane_ready[dest]. This is a combinational path from m_ready and s_sel to s_ready, by design.
- Accept: a beat is accepted when s_valid & s_ready. It loads lane dest only; all other lanes are untouched.
- Latency: an accepted beat appears on m_valid[dest] in the next cycle.
- FSM:
  - IDLE: on accept with s_last=0, set locked_lane = s_sel and go to BURST. On accept with s_last=1 (single-beat packet), stay in IDLE.
  - BURST: s_sel is ignored. On accept with s_last=1, go to IDLE.
  - busy = (FSM==BURST).
- Back-pressure: a stalled destination lane blocks the input. Other lanes continue to drain independently.
- s_data, s_sel and s_last must hold stable while s_valid=1 and s_ready=0. This is the producer's obligation and is checked by an assertion in the bench.
- m_data of an idle lane holds its last value. It is not cleared.

Optional Feature:
- DEMUX_CNT_EN defined:
  - Adds the cnt_bus port plus four CNT_W counters. Lane i's field is cnt_bus[i*CNT_W +: CNT_W].
  - Counter i increments by 1 on every accepted beat routed to lane i, and wraps from 2^CNT_W-1 to 0.
  - Reset value is 0.
- DEMUX_CNT_EN undefined: no cnt_bus port and no counter logic. All other behaviour is identical.

Decomposition:
- Package demux_pkg:
  - constants NUM_LANES=4, SEL_W=2;
  - typedef enum logic {IDLE, BURST} demux_state_t.
- Sub-module demux_lane_reg: one-entry valid/ready register slice.
  - Parameter: DATA_W.
  - Ports: clk, rst_n, load, d_data, d_last, lane_ready, m_valid, m_ready, m_data, m_last.
  - Instantiated 4 times.
- Top level holds the FSM, select/lock logic, s_ready mux and the optional counters.

Test Plan:
- Reset check: hold rst_n=0 with s_valid=1 -> m_valid=4'b0000, busy=0, s_ready reflects empty lanes (1). Release -> first beat accepted normally.
- Single-beat routing: beats (sel=2,data=8'hA5,last=1) then (sel=0,data=8'h3C,last=1), all m_ready=1 -> m_valid[2] with 8'hA5 in cycle+1, then m_valid[0] with 8'h3C in cycle+2. FSM stays IDLE.
- Burst lock: 4-beat packet 8'h10..8'h13, first beat sel=1, later beats sel toggled to 3 -> all four beats exit lane 1. busy=1 after beat 0 and returns to 0 after beat 3. Lane 3 receives nothing.
- Back-pressure isolation: m_ready[1]=0, lane 1 full, input targets lane 1 -> s_ready=0 and data is held. Meanwhile lane 0 drains its pending beat with m_ready[0]=1. Raising m_ready[1] accepts the held beat in the same cycle (pass-through).
- Reset mid-burst: assert rst_n=0 after beat 2 of a 5-beat packet -> all m_valid=0, busy=0. The next beat after release, with sel=3, routes to lane 3.
- With DEMUX_CNT_EN, CNT_W=4: 17 single beats to lane 2 -> lane 2 counter reads 1 (wrapped), other counters read 0.
